// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and constants for the UART transmit buffer.
// The optional watchdog is enabled with the macro UART_TX_BUF_TIMEOUT_EN.
package uart_tx_buffer_pkg;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } tx_state_e;

   localparam int DEFAULT_DEPTH          = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 16384;

   // Bit positions of the buffer status in the UART status read word
   localparam int EMPTY_BIT = 0;
   localparam int FULL_BIT  = 1;
   localparam int OVF_BIT   = 2;
   localparam int COUNT_LSB = 3;

endpackage

// File: rtl/uart_tx_buffer_byte_fifo.sv
// Circular byte FIFO with registered occupancy, empty and full flags.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  empty_q;
   logic                  full_q;
   logic                  push_ok;

   assign push_ok = push_i && (!full_q || pop_i);

   // Occupancy next state: push and pop together leave the count unchanged
   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      case ({push_ok, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two; flags follow the next count
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Byte storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; an entry is only read after it has been written.
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = empty_q;
   assign full_o  = full_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue and transmit sequencer between the UART write strobe and the UART.
// Define UART_TX_BUF_TIMEOUT_EN to add a watchdog on the UART frame-done pulse.
module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int DEPTH          = DEFAULT_DEPTH,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    tx_done,
   input  logic                    clr_overflow,
   output logic                    tx_start,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
`ifdef UART_TX_BUF_TIMEOUT_EN
   ,
   output logic                    timeout
`endif
);

   tx_state_e             state_q;
   logic                  tx_start_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  overflow_q;
   logic                  overflow_d;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  pop;
   logic                  drop;
   logic                  wd_expire;

   // The sequencer is the only consumer and pops only from IDLE with data present
   assign pop  = (state_q == IDLE) && !empty;
   assign drop = wr_en && full && !pop;

   byte_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_en),
      .pop_i   (pop),
      .wdata_i (wr_data),
      .rdata_o (fifo_rdata),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count)
   );

`ifdef UART_TX_BUF_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            timeout_q;
   logic            timeout_d;

   // Expire on the last allowed WAIT cycle if the frame is still not done
   assign wd_expire = (state_q == WAIT) && !tx_done &&
                      (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counts cycles spent in WAIT and restarts for every frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                wd_cnt_q <= '0;
      else if (state_q == WAIT) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      else                      wd_cnt_q <= '0;
   end

   // Sticky timeout: an expiry in the same cycle beats the clear
   always_comb begin
      timeout_d = timeout_q;
      if (wd_expire)         timeout_d = 1'b1;
      else if (clr_overflow) timeout_d = 1'b0;
   end

   // Timeout flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) timeout_q <= 1'b0;
      else       timeout_q <= timeout_d;
   end

   assign timeout = timeout_q;
`else
   assign wd_expire = 1'b0;
`endif

   // Sequencer: every pop goes through IDLE, so a frame following tx_done starts two cycles later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  tx_data_q  <= fifo_rdata;
                  tx_start_q <= 1'b1;
                  state_q    <= START;
               end
            end
            START:   state_q <= WAIT;
            WAIT:    if (tx_done || wd_expire) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Sticky overflow: a dropped write in the same cycle beats the clear
   always_comb begin
      overflow_d = overflow_q;
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
   end

   // Overflow flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=8). The watchdog scenario is
// included when UART_TX_BUF_TIMEOUT_EN is defined (TIMEOUT_CYCLES=100).
module tb_uart_tx_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       tx_done;
   logic       clr_overflow;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       overflow;
`ifdef UART_TX_BUF_TIMEOUT_EN
   logic       timeout;
`endif

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         peak   = 0;
   logic [7:0] sent[$];
   int         start_cyc[$];

   always #5 clk = ~clk;

   uart_tx_buffer #(
      .DEPTH      (8),
      .DATA_WIDTH (8)
`ifdef UART_TX_BUF_TIMEOUT_EN
      , .TIMEOUT_CYCLES (100)
`endif
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .tx_done      (tx_done),
      .clr_overflow (clr_overflow),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow)
`ifdef UART_TX_BUF_TIMEOUT_EN
      , .timeout    (timeout)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample 1 ns after the edge, log transmitted bytes
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (int'(count) > peak) peak = int'(count);
      if (tx_start === 1'b1) begin
         sent.push_back(tx_data);
         start_cyc.push_back(cyc);
      end
   endtask

   task automatic reset_check(input string p);
      check({p, "_tx_start"}, {31'd0, tx_start}, 32'd0);
      check({p, "_tx_data"},  {24'd0, tx_data},  32'd0);
      check({p, "_empty"},    {31'd0, empty},    32'd1);
      check({p, "_full"},     {31'd0, full},     32'd0);
      check({p, "_count"},    {28'd0, count},    32'd0);
      check({p, "_overflow"}, {31'd0, overflow}, 32'd0);
`ifdef UART_TX_BUF_TIMEOUT_EN
      check({p, "_timeout"},  {31'd0, timeout},  32'd0);
`endif
   endtask

   // Answer frames first..last-1 with tx_done 'gap' cycles after their tx_start
   task automatic serve(input int first, input int last, input int gap);
      int b;
      for (int k = first; k < last; k++) begin
         b = 0;
         while (sent.size() <= k && b < 400) begin
            tick();
            b++;
         end
         check("serve_start_seen", (sent.size() > k) ? 32'd1 : 32'd0, 32'd1);
         if (sent.size() <= k) return;
         while (cyc < start_cyc[k] + gap) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_seq [10];
      int         m;
      int         n_before;
      int         b;

      reset        = 1'b1;
      wr_en        = 1'b0;
      wr_data      = 8'h00;
      tx_done      = 1'b0;
      clr_overflow = 1'b0;

      // ---- Reset state ----
      tick();
      tick();
      reset_check("rst");
      reset = 1'b0;
      tick();

      // ---- Single write of 0x41 ----
      wr_en   = 1'b1;
      wr_data = 8'h41;
      tick();
      wr_en = 1'b0;
      check("single_count_n1", {28'd0, count}, 32'd1);
      check("single_nostart_n1", {31'd0, tx_start}, 32'd0);
      tick();
      check("single_start_n2", {31'd0, tx_start}, 32'd1);
      check("single_data_n2", {24'd0, tx_data}, 32'h41);
      check("single_count_n2", {28'd0, count}, 32'd0);
      check("single_empty_n2", {31'd0, empty}, 32'd1);
      tick();
      check("single_start_once", {31'd0, tx_start}, 32'd0);
      repeat (10) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (10) tick();
      check("single_frames", sent.size(), 32'd1);

      // ---- Burst of 8, tx_done 20 cycles after each tx_start ----
      sent.delete();
      start_cyc.delete();
      peak = 0;
      for (int i = 1; i <= 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         tick();
      end
      wr_en = 1'b0;
      serve(0, 8, 20);
      repeat (5) tick();
      check("burst_frames", sent.size(), 32'd8);
      for (int i = 0; i < 8 && i < sent.size(); i++)
         check($sformatf("burst_byte%0d", i), {24'd0, sent[i]}, 32'(i + 1));
      check("burst_peak", peak, 32'd7);
      check("burst_overflow", {31'd0, overflow}, 32'd0);
      check("burst_empty", {31'd0, empty}, 32'd1);
      if (start_cyc.size() >= 2)
         check("burst_done_to_start", start_cyc[1] - start_cyc[0], 32'd22);

      // ---- Fill to full, drop 0xFF, clear, drop-vs-clear priority ----
      sent.delete();
      start_cyc.delete();
      for (int i = 0; i < 9; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h10 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_count", {28'd0, count}, 32'd8);
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_count", {28'd0, count}, 32'd8);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);
      wr_en        = 1'b1;
      wr_data      = 8'hEE;
      clr_overflow = 1'b1;
      tick();
      wr_en        = 1'b0;
      clr_overflow = 1'b0;
      check("ovf_drop_beats_clear", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("ovf_cleared2", {31'd0, overflow}, 32'd0);

      // ---- tx_done while full; pop in IDLE coincides with write 0x55 ----
      m       = cyc;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("pp_idle_count", {28'd0, count}, 32'd8);
      check("pp_idle_nostart", {31'd0, tx_start}, 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      check("pp_start", {31'd0, tx_start}, 32'd1);
      check("pp_start_latency", cyc - m, 32'd2);
      check("pp_data", {24'd0, tx_data}, 32'h11);
      check("pp_count", {28'd0, count}, 32'd8);
      check("pp_overflow", {31'd0, overflow}, 32'd0);
      serve(1, 10, 3);
      repeat (5) tick();
      for (int i = 0; i < 9; i++) exp_seq[i] = 8'h10 + 8'(i);
      exp_seq[9] = 8'h55;
      check("pp_frames", sent.size(), 32'd10);
      for (int i = 0; i < 10 && i < sent.size(); i++)
         check($sformatf("pp_byte%0d", i), {24'd0, sent[i]}, {24'd0, exp_seq[i]});
      check("pp_empty", {31'd0, empty}, 32'd1);

      // ---- Asynchronous reset in WAIT with 3 entries queued ----
      sent.delete();
      start_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h21 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      tick();
      tick();
      check("rstw_pre_count", {28'd0, count}, 32'd3);
      check("rstw_pre_data", {24'd0, tx_data}, 32'h21);
      #2;
      reset = 1'b1;
      #1;
      reset_check("rstw");
      tick();
      reset = 1'b0;
      n_before = sent.size();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (10) tick();
      check("rstw_no_start", sent.size(), 32'(n_before));
      check("rstw_empty", {31'd0, empty}, 32'd1);
      check("rstw_count", {28'd0, count}, 32'd0);

`ifdef UART_TX_BUF_TIMEOUT_EN
      // ---- Watchdog: withhold tx_done for 100 WAIT cycles ----
      sent.delete();
      start_cyc.delete();
      wr_en   = 1'b1;
      wr_data = 8'h61;
      tick();
      wr_data = 8'h62;
      tick();
      wr_en = 1'b0;
      b = 0;
      while (sent.size() < 1 && b < 50) begin
         tick();
         b++;
      end
      check("wd_first_start", (sent.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
      if (sent.size() >= 1) begin
         while (cyc < start_cyc[0] + 100) tick();
         check("wd_not_yet", {31'd0, timeout}, 32'd0);
         tick();
         check("wd_timeout_set", {31'd0, timeout}, 32'd1);
         check("wd_no_start_yet", {31'd0, tx_start}, 32'd0);
         tick();
         check("wd_next_start", {31'd0, tx_start}, 32'd1);
         check("wd_next_data", {24'd0, tx_data}, 32'h62);
         clr_overflow = 1'b1;
         tick();
         clr_overflow = 1'b0;
         check("wd_timeout_clear", {31'd0, timeout}, 32'd0);
         serve(1, 2, 3);
         repeat (5) tick();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
